// File: rtl/win_sprite_fetch_pkg.sv
// win_sprite_fetch_pkg: FSM states, default sprite geometry and transparent index
package win_sprite_fetch_pkg;
  typedef enum logic [1:0] {IDLE, REVEAL, HOLD} state_t;
  localparam int DEF_SPR_W = 150;
  localparam int DEF_SPR_H = 120;
  localparam int DEF_X0 = 245;
  localparam int DEF_Y0 = 180;
  localparam int TRANSP_IDX = 0;
  localparam int ROWS_STEP = 4;
endpackage

// File: rtl/win_sprite_fetch_if.sv
// win_sprite_fetch_if: raster position, frame control, ROM port and pixel outputs
interface win_sprite_fetch_if;
  logic [9:0] DrawX;
  logic [9:0] DrawY;
  logic frame_start;
  logic show_win;
  logic [14:0] rom_addr;
  logic [4:0] rom_data;
  logic sprite_on;
  logic [4:0] pal_idx;
  logic reveal_done;
  modport master (output DrawX, DrawY, frame_start, show_win, rom_data, input rom_addr, sprite_on, pal_idx, reveal_done);
  modport slave (input DrawX, DrawY, frame_start, show_win, rom_data, output rom_addr, sprite_on, pal_idx, reveal_done);
endinterface

// File: rtl/win_sprite_fetch_addr_gen.sv
// sprite_addr_gen: combinational bounding-box test and row-major ROM address
module sprite_addr_gen #(
  parameter int SPR_W = 150,
  parameter int SPR_H = 120,
  parameter int X0 = 245,
  parameter int Y0 = 180
) (
  input  logic [9:0]  DrawX,
  input  logic [9:0]  DrawY,
  output logic        in_box,
  output logic [9:0]  dy,
  output logic [14:0] addr
);
  localparam logic [10:0] XS = 11'(X0);
  localparam logic [10:0] XE = 11'(X0 + SPR_W);
  localparam logic [10:0] YS = 11'(Y0);
  localparam logic [10:0] YE = 11'(Y0 + SPR_H);
  localparam logic [14:0] W15 = 15'(SPR_W);
  logic [9:0] dx;
  assign in_box = {1'b0, DrawX} >= XS && {1'b0, DrawX} < XE && {1'b0, DrawY} >= YS && {1'b0, DrawY} < YE;
  assign dx = DrawX - 10'(X0);
  assign dy = DrawY - 10'(Y0);
  assign addr = in_box ? 15'(dy) * W15 + 15'(dx) : '0;
endmodule

// File: rtl/win_sprite_fetch.sv
// win_sprite_fetch: two-stage sprite pixel fetch with a row-by-row reveal per frame
module win_sprite_fetch
  import win_sprite_fetch_pkg::*;
#(
  parameter int SPR_W = DEF_SPR_W,
  parameter int SPR_H = DEF_SPR_H,
  parameter int X0 = DEF_X0,
  parameter int Y0 = DEF_Y0,
  parameter int TRANSP_IDX = win_sprite_fetch_pkg::TRANSP_IDX
) (
  input logic Clk,
  input logic Reset_n,
  win_sprite_fetch_if.slave bus
);
  localparam logic [15:0] H16 = 16'(SPR_H);
  state_t state;
  logic [15:0] rows_shown;
  logic [15:0] rows_nx;
  logic in_box, in_box_d, reveal_d;
  logic [9:0] dy;
  logic [14:0] addr;
  logic opaque;
  sprite_addr_gen #(.SPR_W(SPR_W), .SPR_H(SPR_H), .X0(X0), .Y0(Y0)) u_addr (
    .DrawX(bus.DrawX),
    .DrawY(bus.DrawY),
    .in_box(in_box),
    .dy(dy),
    .addr(addr)
  );
  assign rows_nx = (rows_shown + 16'(ROWS_STEP) >= H16) ? H16 : rows_shown + 16'(ROWS_STEP);
  // reveal FSM: advances only on frame_start, show_win low always drops back to IDLE
  always_ff @(posedge Clk or negedge Reset_n)
    if (!Reset_n) begin
      state <= IDLE;
      rows_shown <= '0;
    end else if (bus.frame_start) begin
      if (!bus.show_win) begin
        state <= IDLE;
        rows_shown <= '0;
      end else if (state == IDLE) begin
        state <= REVEAL;
        rows_shown <= '0;
      end else if (state == REVEAL) begin
        rows_shown <= rows_nx;
        state <= (rows_nx == H16) ? HOLD : REVEAL;
      end
    end
  // S1: ROM address plus box and reveal flags aligned with it
  always_ff @(posedge Clk or negedge Reset_n)
    if (!Reset_n) begin
      bus.rom_addr <= '0;
      in_box_d <= 1'b0;
      reveal_d <= 1'b0;
    end else begin
      bus.rom_addr <= addr;
      in_box_d <= in_box;
      reveal_d <= state == HOLD || (state == REVEAL && 16'(dy) < rows_shown);
    end
  assign opaque = in_box_d & reveal_d & (bus.rom_data != 5'(TRANSP_IDX));
  // S2: pixel visibility and palette index from the ROM word
  always_ff @(posedge Clk or negedge Reset_n)
    if (!Reset_n) begin
      bus.sprite_on <= 1'b0;
      bus.pal_idx <= '0;
    end else begin
      bus.sprite_on <= opaque;
      bus.pal_idx <= opaque ? bus.rom_data : '0;
    end
  assign bus.reveal_done = state == HOLD;
endmodule

// File: tb/tb_win_sprite_fetch.sv
// tb_win_sprite_fetch: directed checks of fetch pipeline, bounds, reveal FSM and reset
module tb_win_sprite_fetch;
  logic Clk = 1'b0;
  logic Reset_n = 1'b0;
  int compared = 0;
  int mismatched = 0;
  logic [4:0] mem [32768];
  win_sprite_fetch_if bus ();
  win_sprite_fetch dut (.Clk(Clk), .Reset_n(Reset_n), .bus(bus));
  always #5 Clk = ~Clk;
  assign bus.rom_data = mem[bus.rom_addr];
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask
  task automatic tick();
    @(posedge Clk);
    #1;
  endtask
  task automatic pulse();
    bus.frame_start = 1'b1;
    tick();
    bus.frame_start = 1'b0;
  endtask
  task automatic pixel(input string tag, input int x, input int y, input int exp_addr, input bit exp_on, input int exp_pal);
    bus.DrawX = 10'(x);
    bus.DrawY = 10'(y);
    tick();
    chk({tag, "_addr"}, 32'(bus.rom_addr), 32'(exp_addr));
    tick();
    chk({tag, "_on"}, 32'(bus.sprite_on), 32'(exp_on));
    chk({tag, "_pal"}, 32'(bus.pal_idx), 32'(exp_pal));
  endtask
  initial begin
    for (int a = 0; a < 32768; a++) mem[a] = 5'(a);
    bus.DrawX = '0;
    bus.DrawY = '0;
    bus.frame_start = 1'b0;
    bus.show_win = 1'b0;
    #12;
    chk("rst_addr", 32'(bus.rom_addr), 0);
    chk("rst_on", 32'(bus.sprite_on), 0);
    chk("rst_pal", 32'(bus.pal_idx), 0);
    chk("rst_done", 32'(bus.reveal_done), 0);
    Reset_n = 1'b1;
    tick();
    pixel("idle", 246, 181, 151, 0, 0);
    bus.show_win = 1'b1;
    pulse();
    pixel("rev0", 246, 180, 1, 0, 0);
    pulse();
    pulse();
    pixel("rows8_in", 246, 187, 1051, 1, 27);
    pixel("rows8_out", 246, 188, 1201, 0, 0);
    for (int i = 4; i <= 30; i++) pulse();
    chk("done_p30", 32'(bus.reveal_done), 0);
    pulse();
    chk("done_p31", 32'(bus.reveal_done), 1);
    pixel("corner", 245, 180, 0, 0, 0);
    pixel("px151", 246, 181, 151, 1, 23);
    pixel("x_past", 395, 180, 0, 0, 0);
    pixel("y_past", 245, 300, 0, 0, 0);
    pixel("x_before", 244, 200, 0, 0, 0);
    pixel("last", 394, 299, 17999, 1, 15);
    bus.show_win = 1'b0;
    tick();
    tick();
    chk("hold_nofs", 32'(bus.reveal_done), 1);
    pulse();
    chk("drop_done", 32'(bus.reveal_done), 0);
    pixel("drop_px", 246, 181, 151, 0, 0);
    bus.show_win = 1'b1;
    for (int i = 0; i < 11; i++) pulse();
    pixel("rows40", 246, 219, 5851, 1, 27);
    #3;
    Reset_n = 1'b0;
    #1;
    chk("mid_addr", 32'(bus.rom_addr), 0);
    chk("mid_on", 32'(bus.sprite_on), 0);
    chk("mid_pal", 32'(bus.pal_idx), 0);
    chk("mid_done", 32'(bus.reveal_done), 0);
    #10;
    Reset_n = 1'b1;
    tick();
    pixel("post_idle", 246, 181, 151, 0, 0);
    pulse();
    pixel("post_r0", 246, 180, 1, 0, 0);
    pulse();
    pixel("post_r4_in", 246, 183, 451, 1, 3);
    pixel("post_r4_out", 246, 184, 601, 0, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
